gray_updn_ctr: RTL and testbench



---
 rtl/gray_updn_ctr_if.sv | 26 ++
 rtl/gray_updn_ctr.sv | 82 ++++++++
 tb/tb_gray_updn_ctr.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/gray_updn_ctr_if.sv
// Control and status bundle for the Gray up/down counter.
// master drives the count controls; slave is the counter itself.
interface gray_updn_ctr_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_gray;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] bin;
  logic             wrap;
  logic             at_max;
  logic             at_min;

  modport master (
    output en, up, clr, load, load_gray,
    input  q, bin, wrap, at_max, at_min
  );

  modport slave (
    input  en, up, clr, load, load_gray,
    output q, bin, wrap, at_max, at_min
  );
endinterface

// File: rtl/gray_updn_ctr.sv
// Up/down Gray counter with clear, Gray parallel load and optional saturation.
// q is its own flop bank so it stays glitch-free for clock-domain crossing.
module gray_updn_ctr #(
  parameter int WIDTH     = 4,
  parameter int SATURATE  = 0,
  parameter int RESET_VAL = 0
) (
  input logic             clk,
  input logic             reset,
  gray_updn_ctr_if.slave  bus
);

  localparam logic [WIDTH-1:0] RST_B   = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] RST_G   = RST_B ^ (RST_B >> 1);
  localparam logic [WIDTH-1:0] MAX_B   = '1;
  localparam bit               SAT_ON  = (SATURATE != 0);

  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] b_nxt;
  logic [WIDTH-1:0] q_r;
  logic             wrap_r;
  logic             wrap_nxt;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] r;
    r[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH-2; i >= 0; i--) begin
      r[i] = r[i+1] ^ g[i];
    end
    return r;
  endfunction

  always_comb begin
    b_nxt    = b;
    wrap_nxt = 1'b0;
    if (bus.clr) begin
      b_nxt = RST_B;
    end else if (bus.load) begin
      b_nxt = gray2bin(bus.load_gray);
    end else if (bus.en) begin
      if (bus.up) begin
        if (b == MAX_B) begin
          if (!SAT_ON) begin
            b_nxt    = '0;
            wrap_nxt = 1'b1;
          end
        end else begin
          b_nxt = b + 1'b1;
        end
      end else begin
        if (b == '0) begin
          if (!SAT_ON) begin
            b_nxt    = MAX_B;
            wrap_nxt = 1'b1;
          end
        end else begin
          b_nxt = b - 1'b1;
        end
      end
    end
  end

  // q is loaded from the next binary value, never decoded from b.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b      <= RST_B;
      q_r    <= RST_G;
      wrap_r <= 1'b0;
    end else begin
      b      <= b_nxt;
      q_r    <= b_nxt ^ (b_nxt >> 1);
      wrap_r <= wrap_nxt;
    end
  end

  assign bus.bin    = b;
  assign bus.q      = q_r;
  assign bus.wrap   = wrap_r;
  assign bus.at_max = (b == MAX_B);
  assign bus.at_min = (b == '0);

endmodule

// File: tb/tb_gray_updn_ctr.sv
// Directed bench for gray_updn_ctr: wrapping, RESET_VAL=5 and saturating instances.
`timescale 1ns/1ps
module tb_gray_updn_ctr;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_bad;

  gray_updn_ctr_if #(.WIDTH(4)) b0 ();
  gray_updn_ctr_if #(.WIDTH(4)) b1 ();
  gray_updn_ctr_if #(.WIDTH(4)) b2 ();

  gray_updn_ctr #(.WIDTH(4), .SATURATE(0), .RESET_VAL(0)) dut0 (.clk(clk), .reset(reset), .bus(b0));
  gray_updn_ctr #(.WIDTH(4), .SATURATE(0), .RESET_VAL(5)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  gray_updn_ctr #(.WIDTH(4), .SATURATE(1), .RESET_VAL(0)) dut2 (.clk(clk), .reset(reset), .bus(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       load;
    logic       en;
    logic       up;
    logic [3:0] lg;
    logic [3:0] eb;
    logic [3:0] eq;
    logic       ew;
    logic       emax;
    logic       emin;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic c, input logic l, input logic e, input logic u,
                              input logic [3:0] lg, input logic [3:0] eb, input logic [3:0] eq,
                              input logic ew);
    vec_t v;
    v.clr = c; v.load = l; v.en = e; v.up = u; v.lg = lg;
    v.eb = eb; v.eq = eq; v.ew = ew;
    v.emax = (eb == 4'hF);
    v.emin = (eb == 4'h0);
    return v;
  endfunction

  initial begin
    logic [3:0] up_q [16];
    logic [3:0] prev_q;
    logic [3:0] e;
    up_q = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
             4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

    n_vec = 0;
    n_bad = 0;

    // Sixteen up steps: full Gray cycle, wrap only on 15 -> 0.
    for (int i = 0; i < 16; i++)
      tbl.push_back(mk(0, 0, 1, 1, 4'h0, 4'((i + 1) % 16), up_q[i], (i == 15)));
    tbl.push_back(mk(0, 0, 1, 0, 4'h0, 4'd15, 4'b1000, 1));   // down from 0 wraps
    tbl.push_back(mk(0, 0, 1, 0, 4'h0, 4'd14, 4'b1001, 0));
    tbl.push_back(mk(0, 1, 1, 1, 4'b1010, 4'd12, 4'b1010, 0)); // load beats en
    tbl.push_back(mk(0, 0, 1, 1, 4'h0, 4'd13, 4'b1011, 0));
    tbl.push_back(mk(0, 0, 0, 1, 4'h0, 4'd13, 4'b1011, 0));   // idle hold
    tbl.push_back(mk(0, 0, 1, 0, 4'h0, 4'd12, 4'b1010, 0));   // direction flip, no dead cycle
    tbl.push_back(mk(0, 0, 1, 1, 4'h0, 4'd13, 4'b1011, 0));
    tbl.push_back(mk(1, 0, 1, 1, 4'h0, 4'd0,  4'b0000, 0));   // clr beats en
    tbl.push_back(mk(0, 1, 0, 0, 4'b1000, 4'd15, 4'b1000, 0)); // load to max, no wrap
    tbl.push_back(mk(0, 0, 1, 1, 4'h0, 4'd0,  4'b0000, 1));
    tbl.push_back(mk(0, 0, 1, 0, 4'h0, 4'd15, 4'b1000, 1));
    tbl.push_back(mk(0, 1, 1, 0, 4'b1111, 4'd10, 4'b1111, 0));
    tbl.push_back(mk(1, 1, 1, 1, 4'b1000, 4'd0,  4'b0000, 0)); // clr beats load

    b0.en = 0; b0.up = 0; b0.clr = 0; b0.load = 0; b0.load_gray = '0;
    b1.en = 0; b1.up = 0; b1.clr = 0; b1.load = 0; b1.load_gray = '0;
    b2.en = 0; b2.up = 0; b2.clr = 0; b2.load = 0; b2.load_gray = '0;
    reset = 1'b1;

    step();
    step();
    chk("rst bin",    b0.bin,    0);
    chk("rst q",      b0.q,      0);
    chk("rst wrap",   b0.wrap,   0);
    chk("rst at_min", b0.at_min, 1);
    chk("rst at_max", b0.at_max, 0);
    chk("rst5 bin",   b1.bin,    5);
    chk("rst5 q",     b1.q,      4'b0111);
    chk("rst5 at_min", b1.at_min, 0);
    reset = 1'b0;

    foreach (tbl[k]) begin
      prev_q     = b0.q;
      b0.clr     = tbl[k].clr;
      b0.load    = tbl[k].load;
      b0.en      = tbl[k].en;
      b0.up      = tbl[k].up;
      b0.load_gray = tbl[k].lg;
      step();
      chk($sformatf("v%0d bin", k),    b0.bin,    tbl[k].eb);
      chk($sformatf("v%0d q", k),      b0.q,      tbl[k].eq);
      chk($sformatf("v%0d wrap", k),   b0.wrap,   tbl[k].ew);
      chk($sformatf("v%0d at_max", k), b0.at_max, tbl[k].emax);
      chk($sformatf("v%0d at_min", k), b0.at_min, tbl[k].emin);
      if (tbl[k].en && !tbl[k].clr && !tbl[k].load)
        chk($sformatf("v%0d onebit", k), $countones(prev_q ^ b0.q), 1);
    end
    b0.clr = 0; b0.load = 0; b0.en = 0; b0.up = 0;

    // RESET_VAL=5: count once, then clr+load+en together must give 5.
    b1.en = 1; b1.up = 1;
    step();
    chk("rv5 count bin", b1.bin, 6);
    chk("rv5 count q",   b1.q,   4'b0101);
    b1.clr = 1; b1.load = 1; b1.load_gray = 4'b1111;
    step();
    chk("rv5 prio bin", b1.bin, 5);
    chk("rv5 prio q",   b1.q,   4'b0111);
    b1.clr = 0; b1.load = 0; b1.en = 0;

    // Saturation: up past max, then down past zero.
    b2.en = 1; b2.up = 1;
    for (int i = 1; i <= 18; i++) begin
      step();
      e = (i < 15) ? 4'(i) : 4'd15;
      chk($sformatf("sat up%0d bin", i),  b2.bin,  e);
      chk($sformatf("sat up%0d q", i),    b2.q,    e ^ (e >> 1));
      chk($sformatf("sat up%0d wrap", i), b2.wrap, 0);
    end
    b2.up = 0;
    for (int i = 1; i <= 17; i++) begin
      step();
      e = (i < 15) ? 4'(15 - i) : 4'd0;
      chk($sformatf("sat dn%0d bin", i),  b2.bin,  e);
      chk($sformatf("sat dn%0d q", i),    b2.q,    e ^ (e >> 1));
      chk($sformatf("sat dn%0d wrap", i), b2.wrap, 0);
    end
    b2.en = 0;

    // Async reset while a wrap pulse is live (bin=15 after down-wrap).
    b0.clr = 1;
    step();
    b0.clr = 0; b0.en = 1; b0.up = 0;
    step();
    chk("pre-rst wrap", b0.wrap, 1);
    chk("pre-rst bin",  b0.bin,  15);
    #2 reset = 1'b1;
    #1;
    chk("async bin",  b0.bin,  0);
    chk("async q",    b0.q,    0);
    chk("async wrap", b0.wrap, 0);
    b0.en = 0;
    step();
    reset = 1'b0;

    // Async reset at bin=9, then resume counting from 0.
    b0.load = 1; b0.load_gray = 4'b1101;
    step();
    b0.load = 0;
    chk("load9 bin", b0.bin, 9);
    #2 reset = 1'b1;
    #1;
    chk("async9 bin", b0.bin, 0);
    chk("async9 q",   b0.q,   0);
    step();
    reset = 1'b0;
    b0.en = 1; b0.up = 1;
    step();
    chk("resume bin", b0.bin, 1);
    chk("resume q",   b0.q,   4'b0001);
    b0.en = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
